// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin grant arbiter.
package arb_pkg;

    // Default number of requesters sharing the resource
    localparam int unsigned ARB_N_REQ_DEF    = 4;
    // Default grant-hold limit before a forced revoke (timeout build only)
    localparam int unsigned ARB_MAX_HOLD_DEF = 16;

    // Arbiter control states
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Rotated priority encoder: first asserted request strictly after 'last',
// wrapping around. Built as a masked priority encode over a doubled request
// vector so the wrap needs no special case.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_valid
);

    localparam int unsigned DW = 2 * N_REQ;
    localparam int          NI = int'(N_REQ);

    logic [DW-1:0] w_dbl;
    logic [DW-1:0] w_mask;
    logic [DW-1:0] w_cand;

    // Window the doubled vector to positions last+1 .. last+N_REQ
    always_comb begin
        w_dbl  = {req, req};
        w_mask = '0;
        for (int i = 0; i < int'(DW); i++) begin
            w_mask[i] = (i > int'(last)) && (i <= int'(last) + NI);
        end
        w_cand = w_dbl & w_mask;
    end

    // Lowest set candidate wins; fold the upper half back onto 0..N_REQ-1
    always_comb begin
        pick_idx   = '0;
        pick_valid = |req;
        for (int i = int'(DW) - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                pick_idx = (i >= NI) ? IDX_W'(i - NI) : IDX_W'(i);
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with registered one-hot grant held until the
// winner drops its request. Optional forced revoke after MAX_HOLD cycles
// is compiled in with the ARB_HOLD_TIMEOUT_EN macro.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ    = ARB_N_REQ_DEF,
    parameter int unsigned IDX_W    = $clog2(N_REQ),
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    // Elaboration-time parameter sanity
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("rr_grant_arbiter: N_REQ must be in 2..16");
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("rr_grant_arbiter: MAX_HOLD must be >= 2");
    end

    arb_state_e       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_grant_valid;
    logic             r_timeout;
    logic [IDX_W-1:0] r_last;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic [N_REQ-1:0] w_pick_onehot;
    logic             w_holder_req;
    logic             w_load;
    logic             w_expire;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .last       (r_last),
        .pick_idx   (w_pick_idx),
        .pick_valid (w_pick_valid)
    );

    assign w_pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
    assign w_holder_req  = req[r_grant_idx];

    // A new grant is taken from IDLE or on the holder's release cycle
    assign w_load = enable && w_pick_valid &&
                    ((r_state == ARB_IDLE) ||
                     ((r_state == ARB_GRANT) && !w_holder_req));

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] r_hold;

    assign w_expire = (r_state == ARB_GRANT) && w_holder_req &&
                      (r_hold == HOLD_W'(MAX_HOLD - 1));

    // Hold counter: cleared on each new grant, counts cycles the holder keeps it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_load) begin
            r_hold <= '0;
        end else if ((r_state == ARB_GRANT) && w_holder_req && !w_expire) begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // Arbiter state, grant registers and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ARB_IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_last        <= IDX_W'(N_REQ - 1);
        end else begin
            r_timeout <= w_expire;
            if (w_load) begin
                r_state       <= ARB_GRANT;
                r_grant       <= w_pick_onehot;
                r_grant_idx   <= w_pick_idx;
                r_grant_valid <= 1'b1;
                r_last        <= w_pick_idx;
            end else begin
                case (r_state)
                    ARB_IDLE: begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                    end
                    ARB_GRANT: begin
                        // Release with nothing to hand over, or forced revoke
                        if (!w_holder_req || w_expire) begin
                            r_state       <= ARB_IDLE;
                            r_grant       <= '0;
                            r_grant_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state       <= ARB_IDLE;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule : rr_grant_arbiter
